// File: rtl/vga_sync_gen.sv
// VGA raster timing generator for the ADV7123 DAC path: divides CLK down to the
// pixel rate and produces HS/VS/BLANK, the pixel clock and visible-area coordinates.
module vga_sync_gen #(
   parameter int   DIV     = 2,
   parameter int   H_DISP  = 640,
   parameter int   H_FP    = 16,
   parameter int   H_PULSE = 96,
   parameter int   H_BP    = 48,
   parameter int   V_DISP  = 480,
   parameter int   V_FP    = 10,
   parameter int   V_PULSE = 2,
   parameter int   V_BP    = 33,
   parameter logic HS_POL  = 1'b0,
   parameter logic VS_POL  = 1'b0,
   parameter int   XW      = 11,
   parameter int   YW      = 10
) (
   input  logic          CLK,
   input  logic          NRST,
   input  logic          EN,
   output logic          VGA_CLK,
   output logic          VGA_HS,
   output logic          VGA_VS,
   output logic          VGA_BLANK,
   output logic          VGA_SYNC,
   output logic [XW-1:0] x,
   output logic [YW-1:0] y,
   output logic          active,
   output logic          line_start,
   output logic          frame_start
);

   localparam int H_TOT = H_DISP + H_FP + H_PULSE + H_BP;
   localparam int V_TOT = V_DISP + V_FP + V_PULSE + V_BP;
   localparam int PW    = (DIV > 2) ? $clog2(DIV) : 1;

   localparam logic [PW-1:0] PH_LAST      = PW'(DIV - 1);
   localparam logic [PW-1:0] PH_HALF      = PW'(DIV / 2);
   localparam logic [XW-1:0] H_LAST       = XW'(H_TOT - 1);
   localparam logic [XW-1:0] H_FP_START   = XW'(H_DISP);
   localparam logic [XW-1:0] H_SYNC_START = XW'(H_DISP + H_FP);
   localparam logic [XW-1:0] H_BP_START   = XW'(H_DISP + H_FP + H_PULSE);
   localparam logic [YW-1:0] V_LAST       = YW'(V_TOT - 1);
   localparam logic [YW-1:0] V_FP_START   = YW'(V_DISP);
   localparam logic [YW-1:0] V_SYNC_START = YW'(V_DISP + V_FP);
   localparam logic [YW-1:0] V_BP_START   = YW'(V_DISP + V_FP + V_PULSE);

   typedef enum logic [1:0] {DISP, FP, SYNC, BP} seg_t;

   logic [PW-1:0] phase, phase_nxt;
   logic [XW-1:0] hcnt, hcnt_nxt;
   logic [YW-1:0] vcnt, vcnt_nxt;
   seg_t          hstate, hstate_nxt;
   seg_t          vstate, vstate_nxt;
   logic          start_pend;
   logic          tick;
   logic          hwrap;
   logic          vis_nxt;

   assign VGA_SYNC = 1'b0;

   // The first enabled cycle after reset acts as the tick that opens pixel (0,0),
   // so the post-reset frame_start lines up with the steady-state one.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path infers a latch.
      phase_nxt = phase;
      hcnt_nxt  = hcnt;
      vcnt_nxt  = vcnt;
      tick      = EN && !start_pend && (phase == PH_LAST);
      hwrap     = (hcnt == H_LAST);
      if (EN && !start_pend) begin
         phase_nxt = tick ? '0 : phase + PW'(1);
         if (tick) begin
            hcnt_nxt = hwrap ? '0 : hcnt + XW'(1);
            if (hwrap)
               vcnt_nxt = (vcnt == V_LAST) ? '0 : vcnt + YW'(1);
         end
      end
   end

   always_comb begin
      hstate_nxt = hstate;
      case (hstate)
         DISP:    if (hcnt_nxt == H_FP_START)   hstate_nxt = FP;
         FP:      if (hcnt_nxt == H_SYNC_START) hstate_nxt = SYNC;
         SYNC:    if (hcnt_nxt == H_BP_START)   hstate_nxt = BP;
         BP:      if (hcnt_nxt == '0)           hstate_nxt = DISP;
         default: hstate_nxt = DISP;
      endcase
   end

   always_comb begin
      vstate_nxt = vstate;
      case (vstate)
         DISP:    if (vcnt_nxt == V_FP_START)   vstate_nxt = FP;
         FP:      if (vcnt_nxt == V_SYNC_START) vstate_nxt = SYNC;
         SYNC:    if (vcnt_nxt == V_BP_START)   vstate_nxt = BP;
         BP:      if (vcnt_nxt == '0)           vstate_nxt = DISP;
         default: vstate_nxt = DISP;
      endcase
   end

   assign vis_nxt = EN && (hstate_nxt == DISP) && (vstate_nxt == DISP);

   // Outputs are decoded from next-state values so they move on the same edge as the counters.
   always_ff @(posedge CLK or negedge NRST) begin
      if (!NRST) begin
         phase       <= '0;
         hcnt        <= '0;
         vcnt        <= '0;
         hstate      <= DISP;
         vstate      <= DISP;
         start_pend  <= 1'b1;
         VGA_CLK     <= 1'b0;
         VGA_HS      <= ~HS_POL;
         VGA_VS      <= ~VS_POL;
         VGA_BLANK   <= 1'b0;
         active      <= 1'b0;
         x           <= '0;
         y           <= '0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         phase       <= phase_nxt;
         hcnt        <= hcnt_nxt;
         vcnt        <= vcnt_nxt;
         hstate      <= hstate_nxt;
         vstate      <= vstate_nxt;
         start_pend  <= start_pend && !EN;
         VGA_CLK     <= (phase_nxt >= PH_HALF);
         VGA_HS      <= (hstate_nxt == SYNC) ? HS_POL : ~HS_POL;
         VGA_VS      <= (vstate_nxt == SYNC) ? VS_POL : ~VS_POL;
         VGA_BLANK   <= vis_nxt;
         active      <= vis_nxt;
         line_start  <= EN && (start_pend || (tick && hwrap));
         frame_start <= EN && (start_pend || (tick && hwrap && (vcnt == V_LAST)));
         if (EN) begin
            x <= vis_nxt ? hcnt_nxt : '0;
            y <= vis_nxt ? vcnt_nxt : '0;
         end
      end
   end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Generates VGA raster timing (HS, VS, BLANK, SYNC, pixel clock) and current pixel coordinates for the ADV7123 DAC path.
- Sits directly under the fpga top level. It drives the VGA_* board pins and feeds x/y/active to the downstream pixel-colour stage.
- The system clock CLK is divided down to the pixel rate internally, so no PLL is needed.

Parameters:
- DIV, 2, CLK cycles per pixel; must be even and at least 2.
- H_DISP, 640, visible pixels per line.
- H_FP, 16, horizontal front porch in pixels.
- H_PULSE, 96, HS pulse width in pixels.
- H_BP, 48, horizontal back porch in pixels.
- V_DISP, 480, visible lines per frame.
- V_FP, 10, vertical front porch in lines.
- V_PULSE, 2, VS pulse width in lines.
- V_BP, 33, vertical back porch in lines.
- HS_POL, 0, active level of VGA_HS.
- VS_POL, 0, active level of VGA_VS.
- XW, 11, width of hcnt and x.
- YW, 10, width of vcnt and y.

Ports:
- CLK in 1: system clock (50 MHz).
- NRST in 1: asynchronous active-low reset.
- EN in 1: run enable; when low the raster freezes.
- VGA_CLK out 1: pixel clock to the DAC.
- VGA_HS out 1: horizontal sync.
- VGA_VS out 1: vertical sync.
- VGA_BLANK out 1: active-low blank; 1 means visible.
- VGA_SYNC out 1: composite sync on green; tied inactive at 0.
- x out XW: column within the visible area.
- y out YW: line within the visible area.
- active out 1: 1 while the current pixel is visible.
- line_start out 1: 1-CLK pulse at pixel (0, any line).
- frame_start out 1: 1-CLK pulse at pixel (0, 0).

Behaviour:
- Interface: one clock, CLK; reset NRST, asynchronous and active-low. All flops reset asynchronously and release synchronously to CLK.
- Reset values:
  - phase, hcnt, vcnt = 0.
  - VGA_CLK = 0, VGA_BLANK = 0, VGA_SYNC = 0.
  - VGA_HS = ~HS_POL, VGA_VS = ~VS_POL.
  - x, y = 0; active, line_start, frame_start = 0.
- Pixel divider:
  - phase counts 0..DIV-1 while EN = 1.
  - tick is asserted when phase = DIV-1.
  - VGA_CLK = 1 while phase is at least DIV/2 (registered). Its rising edge falls mid-pixel, so DAC data is stable at the edge.
- Totals: H_TOT = H_DISP+H_FP+H_PULSE+H_BP (800). V_TOT = V_DISP+V_FP+V_PULSE+V_BP (525).
- Horizontal FSM, advanced on tick, states DISP -> FP -> SYNC -> BP -> DISP:
  - hcnt increments on each tick; at H_TOT-1 it wraps to 0.
  - DISP covers hcnt 0..H_DISP-1.
  - FP covers H_DISP..H_DISP+H_FP-1.
  - SYNC covers the next H_PULSE counts.
  - BP covers the rest.
- Vertical FSM, same four states:
  - Advances only on a tick where hcnt wraps.
  - vcnt wraps from V_TOT-1 to 0.
  - Line ranges are analogous to the horizontal ones.
- Outputs are registered and decoded from next-state values, so they change on the same CLK edge as the counters (zero added latency):
  - VGA_HS = HS_POL while hstate = SYNC, else ~HS_POL.
  - VGA_VS = VS_POL while vstate = SYNC, else ~VS_POL. VS edges align with the hcnt wrap.
  - active = VGA_BLANK = (hstate = DISP and vstate = DISP).
  - x = hcnt and y = vcnt while active. Otherwise x and y hold 0.
  - line_start is high for the first CLK of hcnt = 0. frame_start is high for the first CLK of hcnt = 0 with vcnt = 0. Both last exactly 1 CLK, not DIV.
- EN = 0:
  - phase, hcnt and vcnt hold; tick is suppressed.
  - VGA_CLK holds; HS and VS hold their current levels.
  - VGA_BLANK and active are forced to 0; pulses are 0.
  - When EN returns to 1, counting resumes from the held position; no restart.
- Reset asserted mid-frame: all outputs go to reset values immediately, without waiting for CLK. The first tick after release starts pixel (0, 0) of a new frame; frame_start fires 1 CLK after release.

Test Plan:
- Reset, then EN = 1 with defaults, over 2 frames:
  - frame_start period = 840000 CLK; line_start period = 1600 CLK.
  - VGA_HS low for 192 CLK, starting 1312 CLK after line_start.
  - VGA_VS low for 3200 CLK, starting at line 490.
- Visible area, defaults: VGA_BLANK high for exactly 1280 CLK per line on lines 0..479 and never high on lines 480..524. x runs 0..639 and y runs 0..479, each value held 2 CLK.
- Reduced parameters (H 4/1/2/1, V 3/1/1/1, DIV 2): HS, VS and BLANK match a cycle-exact golden model over 3 frames, including the hcnt wrap 7 -> 0 and the vcnt wrap 5 -> 0.
- EN dropped for 37 CLK mid-line at x = 100: BLANK is 0 throughout the gap and x/y are frozen. After EN returns, the next x is 100 (or 101 if the gap fell on a tick), and total frame length grows by exactly 37 CLK.
- NRST pulsed low for 3 CLK mid-VS pulse:
  - VGA_VS goes high asynchronously, before the next CLK edge.
  - After release: frame_start is seen, then 840000 CLK to the next frame_start.
- DIV = 4, otherwise defaults: VGA_CLK is high 2 CLK and low 2 CLK, and frame_start period = 1680000 CLK.
